endec_result_deframer: RTL and testbench

Downstream AXI4-Stream consumer for the encoder/decoder core's result stream. It collects each 11-beat, 64-bit result packet into a 704-bit word, splits the word into the 576-bit encoder result and the 128-bit decoder result, and holds both behind a valid/ready handshake for the host-side result sink. It enforces packet length against `tlast` and counts delivered packets.

---
 rtl/endec_result_deframer.sv | 193 +++++++++++++++++++
 tb/tb_endec_result_deframer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/endec_result_deframer.sv
// ---------------------------------------------------------------------------
// endec_result_deframer
//
// Collects 11-beat, 64-bit result packets from the encoder/decoder core into
// a 704-bit word. The word is split into the 576-bit encoder result (beats
// 0-8) and the 128-bit decoder result (beats 9-10). Both are held behind a
// valid/ready handshake for the host-side result sink. Delivered results are
// counted.
//
// Build option:
//   ENDEC_DEFRAMER_LEN_CHECK_EN - when defined, packet length is checked
//     against tlast. A short packet is dropped. A long packet is flagged and
//     its tail is drained up to tlast. Either case raises a one-cycle
//     o_len_err pulse. When undefined, tlast is ignored, a packet completes
//     on every 11th accepted beat, and o_len_err is tied low.
//
// Ports:
//   sys_clk         in   clock
//   rst_n           in   synchronous active-low reset
//   s_axis_tdata    in   result beat (DATA_W bits)
//   s_axis_tvalid   in   beat valid
//   s_axis_tlast    in   last beat of packet
//   s_axis_tready   out  beat accept (low while a result is held)
//   o_encoder_data  out  packet bits [575:0]
//   o_decoder_data  out  packet bits [703:576]
//   o_valid         out  result held and valid
//   i_ready         in   sink accepts the held result
//   o_len_err       out  one-cycle pulse on a malformed packet
//   o_pkt_count     out  results delivered (wraps at 16 bits)
// ---------------------------------------------------------------------------
module endec_result_deframer #(
  parameter int DATA_W = 64,
  parameter int BEATS  = 11
) (
  input  logic                          sys_clk,
  input  logic                          rst_n,
  input  logic [DATA_W-1:0]             s_axis_tdata,
  input  logic                          s_axis_tvalid,
  input  logic                          s_axis_tlast,
  output logic                          s_axis_tready,
  output logic [DATA_W*(BEATS-2)-1:0]   o_encoder_data,
  output logic [2*DATA_W-1:0]           o_decoder_data,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic                          o_len_err,
  output logic [15:0]                   o_pkt_count
);

  localparam int         ENC_BEATS = BEATS - 2;
  localparam logic [3:0] LAST_IDX  = 4'(BEATS - 1);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    HOLD    = 2'd1
`ifdef ENDEC_DEFRAMER_LEN_CHECK_EN
    ,
    DRAIN   = 2'd2
`endif
  } state_t;

  state_t state, state_nxt;

  logic [3:0]        beat_cnt, beat_cnt_nxt;
  // Beats 0..BEATS-2 are buffered; the final beat goes straight to the
  // output registers together with the buffer contents.
  logic [DATA_W-1:0] beat_buf [0:BEATS-2];

  logic accept;
  logic buf_wr;
  logic load_result;
  logic pkt_inc;
  logic last_beat;

  assign accept    = s_axis_tvalid && s_axis_tready;
  assign last_beat = (beat_cnt == LAST_IDX);

`ifdef ENDEC_DEFRAMER_LEN_CHECK_EN
  logic len_err_nxt;
`else
  logic unused_tlast;
  assign unused_tlast = s_axis_tlast;
`endif

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state <= COLLECT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    beat_cnt_nxt  = beat_cnt;
    s_axis_tready = (state != HOLD);
    buf_wr        = 1'b0;
    load_result   = 1'b0;
    pkt_inc       = 1'b0;
`ifdef ENDEC_DEFRAMER_LEN_CHECK_EN
    len_err_nxt   = 1'b0;
`endif
    case (state)
      COLLECT: begin
        if (accept) begin
          buf_wr       = !last_beat;
          beat_cnt_nxt = beat_cnt + 4'd1;
`ifdef ENDEC_DEFRAMER_LEN_CHECK_EN
          if (last_beat && s_axis_tlast) begin
            load_result  = 1'b1;
            beat_cnt_nxt = 4'd0;
            state_nxt    = HOLD;
          end else if (last_beat) begin
            // Long packet: flag once, then swallow the tail up to tlast.
            len_err_nxt  = 1'b1;
            beat_cnt_nxt = 4'd0;
            state_nxt    = DRAIN;
          end else if (s_axis_tlast) begin
            // Short packet: drop what was collected and start over.
            len_err_nxt  = 1'b1;
            beat_cnt_nxt = 4'd0;
          end
`else
          if (last_beat) begin
            load_result  = 1'b1;
            beat_cnt_nxt = 4'd0;
            state_nxt    = HOLD;
          end
`endif
        end
      end
      HOLD: begin
        if (i_ready) begin
          pkt_inc   = 1'b1;
          state_nxt = COLLECT;
        end
      end
`ifdef ENDEC_DEFRAMER_LEN_CHECK_EN
      DRAIN: begin
        if (accept && s_axis_tlast) begin
          state_nxt = COLLECT;
        end
      end
`endif
      default: begin
        state_nxt    = COLLECT;
        beat_cnt_nxt = 4'd0;
      end
    endcase
  end

  // Beat buffer, counters and result registers. The result registers only
  // load on entry to HOLD and keep their value after the handshake.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      beat_cnt       <= 4'd0;
      o_encoder_data <= '0;
      o_decoder_data <= '0;
      o_pkt_count    <= 16'd0;
      for (int k = 0; k < BEATS - 1; k++) begin
        beat_buf[k] <= '0;
      end
    end else begin
      beat_cnt <= beat_cnt_nxt;
      if (buf_wr) begin
        beat_buf[beat_cnt] <= s_axis_tdata;
      end
      if (load_result) begin
        for (int k = 0; k < ENC_BEATS; k++) begin
          o_encoder_data[k*DATA_W +: DATA_W] <= beat_buf[k];
        end
        o_decoder_data <= {s_axis_tdata, beat_buf[BEATS-2]};
      end
      if (pkt_inc) begin
        o_pkt_count <= o_pkt_count + 16'd1;
      end
    end
  end

  assign o_valid = (state == HOLD);

`ifdef ENDEC_DEFRAMER_LEN_CHECK_EN
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      o_len_err <= 1'b0;
    end else begin
      o_len_err <= len_err_nxt;
    end
  end
`else
  assign o_len_err = 1'b0;
`endif

endmodule

// File: tb/tb_endec_result_deframer.sv
// ---------------------------------------------------------------------------
// tb_endec_result_deframer
//
// Directed bench for endec_result_deframer. A packet-level model (queue of
// accepted beats, held result, delivered count) predicts every output each
// cycle; a few hand-computed literals pin the model. Honours
// ENDEC_DEFRAMER_LEN_CHECK_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_endec_result_deframer;

  localparam int BEATS = 11;

  logic          sys_clk = 1'b0;
  logic          rst_n;
  logic [63:0]   s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tlast;
  logic          s_axis_tready;
  logic [575:0]  o_encoder_data;
  logic [127:0]  o_decoder_data;
  logic          o_valid;
  logic          i_ready;
  logic          o_len_err;
  logic [15:0]   o_pkt_count;

  int checks = 0;
  int errors = 0;

  endec_result_deframer dut (
    .sys_clk        (sys_clk),
    .rst_n          (rst_n),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tlast   (s_axis_tlast),
    .s_axis_tready  (s_axis_tready),
    .o_encoder_data (o_encoder_data),
    .o_decoder_data (o_decoder_data),
    .o_valid        (o_valid),
    .i_ready        (i_ready),
    .o_len_err      (o_len_err),
    .o_pkt_count    (o_pkt_count)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic checkOutput(input string name, input logic [703:0] act,
                             input logic [703:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] beatVal(input logic [7:0] seed, input int k);
    return {seed, 48'h0, 8'(k)};
  endfunction

  function automatic logic [703:0] makeWord(input logic [7:0] seed);
    logic [703:0] w;
    for (int k = 0; k < BEATS; k++) w[64*k +: 64] = beatVal(seed, k);
    return w;
  endfunction

  // Packet-level reference model.
  logic          mValid = 1'b0;
  logic          mHold, mDrain, mErr;
  logic [575:0]  mEnc;
  logic [127:0]  mDec;
  logic [15:0]   mCnt;
  logic [63:0]   q[$];

  task automatic deliverModel();
    logic [703:0] w;
    for (int k = 0; k < BEATS; k++) w[64*k +: 64] = q[k];
    mEnc  = w[575:0];
    mDec  = w[703:576];
    mHold = 1'b1;
    q.delete();
  endtask

  always @(posedge sys_clk) begin
    if (!rst_n) begin
      mValid = 1'b1;
      mHold  = 1'b0;
      mDrain = 1'b0;
      mErr   = 1'b0;
      mEnc   = '0;
      mDec   = '0;
      mCnt   = 16'd0;
      q.delete();
    end else if (mValid) begin
      mErr = 1'b0;
      if (mHold) begin
        if (i_ready) begin
          mHold = 1'b0;
          mCnt  = mCnt + 16'd1;
        end
      end else if (s_axis_tvalid) begin
        if (mDrain) begin
          if (s_axis_tlast) mDrain = 1'b0;
        end else begin
          q.push_back(s_axis_tdata);
`ifdef ENDEC_DEFRAMER_LEN_CHECK_EN
          if (q.size() == BEATS) begin
            if (s_axis_tlast) deliverModel();
            else begin
              mErr = 1'b1;
              mDrain = 1'b1;
              q.delete();
            end
          end else if (s_axis_tlast) begin
            mErr = 1'b1;
            q.delete();
          end
`else
          if (q.size() == BEATS) deliverModel();
`endif
        end
      end
    end
  end

  always @(negedge sys_clk) begin
    if (mValid) begin
      checkOutput("tready",  s_axis_tready,  !mHold);
      checkOutput("valid",   o_valid,        mHold);
      checkOutput("len_err", o_len_err,      mErr);
      checkOutput("count",   o_pkt_count,    mCnt);
      checkOutput("enc",     o_encoder_data, mEnc);
      checkOutput("dec",     o_decoder_data, mDec);
    end
  end

  // Side counters for the throughput and error-pulse literals.
  logic measuring = 1'b0;
  int   cyc = 0;
  int   lowCnt = 0;
  int   errPulses = 0;

  always @(posedge sys_clk) begin
    if (measuring) begin
      cyc++;
      if (!s_axis_tready) lowCnt++;
    end
  end

  always @(negedge sys_clk) begin
    if (rst_n === 1'b1 && o_len_err === 1'b1) errPulses++;
  end

  // Presents one beat and returns on the negedge after it was accepted.
  task automatic applyStimulus(input logic [63:0] data, input logic last);
    logic hs;
    logic done;
    done = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = data;
    s_axis_tlast  = last;
    for (int i = 0; i < 200 && !done; i++) begin
      hs = s_axis_tready;
      @(negedge sys_clk);
      if (hs) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL beat_accept_timeout: got no handshake expected handshake within 200 cycles");
    end
  endtask

  task automatic sendPacket(input logic [7:0] seed, input int nbeats, input int lastIdx);
    for (int k = 0; k < nbeats; k++) applyStimulus(beatVal(seed, k), k == lastIdx);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    repeat (2) @(negedge sys_clk);
    rst_n = 1'b1;
    errPulses = 0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [703:0] w;
    logic [703:0] w2;
    rst_n = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    s_axis_tdata = '0;
    i_ready = 1'b1;
    @(negedge sys_clk);
    doReset();

    // Reset values
    checkOutput("rst_tready", s_axis_tready, 1'b1);
    checkOutput("rst_valid",  o_valid,       1'b0);
    checkOutput("rst_count",  o_pkt_count,   16'd0);
    checkOutput("rst_enc",    o_encoder_data, 576'd0);
    checkOutput("rst_dec",    o_decoder_data, 128'd0);

    // Single packet, beat k = k
    sendPacket(8'h00, 11, 10);
    checkOutput("single_valid_latency", o_valid, 1'b1);
    repeat (2) @(negedge sys_clk);
    checkOutput("single_enc_lo", o_encoder_data[63:0],    64'h00);
    checkOutput("single_enc_hi", o_encoder_data[575:512], 64'h08);
    checkOutput("single_dec_hi", o_decoder_data[127:64],  64'h0A);
    checkOutput("single_count",  o_pkt_count, 16'd1);

    // Three back-to-back packets
    doReset();
    measuring = 1'b1;
    for (int p = 0; p < 3; p++) sendPacket(8'(p + 1), 11, 10);
    for (int i = 0; i < 20 && o_pkt_count !== 16'd3; i++) @(negedge sys_clk);
    measuring = 1'b0;
    checkOutput("b2b_cycles",     cyc,    36);
    checkOutput("b2b_tready_low", lowCnt, 3);
    checkOutput("b2b_count", o_pkt_count, 16'd3);

    // Sink back-pressure while the next packet waits
    doReset();
    i_ready = 1'b0;
    sendPacket(8'h11, 11, 10);
    w = makeWord(8'h11);
    fork
      sendPacket(8'h12, 11, 10);
      begin
        repeat (20) @(negedge sys_clk);
        checkOutput("bp_tready", s_axis_tready, 1'b0);
        checkOutput("bp_enc_stable", o_encoder_data, w[575:0]);
        checkOutput("bp_dec_stable", o_decoder_data, w[703:576]);
        i_ready = 1'b1;
      end
    join
    repeat (3) @(negedge sys_clk);
    w = makeWord(8'h12);
    checkOutput("bp_next_enc", o_encoder_data, w[575:0]);
    checkOutput("bp_next_dec", o_decoder_data, w[703:576]);
    checkOutput("bp_count",    o_pkt_count, 16'd2);

    // Short packet then a valid packet
    doReset();
    sendPacket(8'h21, 5, 4);
    sendPacket(8'h22, 11, 10);
    repeat (3) @(negedge sys_clk);
`ifdef ENDEC_DEFRAMER_LEN_CHECK_EN
    w = makeWord(8'h22);
    checkOutput("short_err_pulses", errPulses, 1);
`else
    for (int k = 0; k < 5; k++) w[64*k +: 64] = beatVal(8'h21, k);
    for (int k = 0; k < 6; k++) w[64*(k+5) +: 64] = beatVal(8'h22, k);
    checkOutput("short_err_pulses", errPulses, 0);
`endif
    checkOutput("short_enc",   o_encoder_data, w[575:0]);
    checkOutput("short_dec",   o_decoder_data, w[703:576]);
    checkOutput("short_count", o_pkt_count, 16'd1);

    // Long packet (13 beats) then a valid packet
    doReset();
    sendPacket(8'h31, 13, 12);
    sendPacket(8'h32, 11, 10);
    repeat (3) @(negedge sys_clk);
`ifdef ENDEC_DEFRAMER_LEN_CHECK_EN
    w2 = makeWord(8'h32);
    checkOutput("long_err_pulses", errPulses, 1);
    checkOutput("long_count", o_pkt_count, 16'd1);
`else
    w2[63:0]    = beatVal(8'h31, 11);
    w2[127:64]  = beatVal(8'h31, 12);
    for (int k = 0; k < 9; k++) w2[64*(k+2) +: 64] = beatVal(8'h32, k);
    checkOutput("long_err_pulses", errPulses, 0);
    checkOutput("long_count", o_pkt_count, 16'd2);
`endif
    checkOutput("long_enc", o_encoder_data, w2[575:0]);
    checkOutput("long_dec", o_decoder_data, w2[703:576]);

    // Reset after beat 6, then a full packet
    doReset();
    sendPacket(8'h41, 7, 99);
    doReset();
    sendPacket(8'h42, 11, 10);
    repeat (3) @(negedge sys_clk);
    w = makeWord(8'h42);
    checkOutput("midrst_enc",   o_encoder_data, w[575:0]);
    checkOutput("midrst_dec",   o_decoder_data, w[703:576]);
    checkOutput("midrst_count", o_pkt_count, 16'd1);

    repeat (2) @(negedge sys_clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
